// File: rtl/dmem_resp.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed latency.
// Optional DMEM_RESP_RANGE_CHECK_EN flags out-of-range addresses instead of wrapping them.
module dmem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and response data is held stable while valid waits.

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         DIRECT   = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_idx;
  logic          lat_oob;
  logic          lat_ren;
  logic          lat_wen;
  logic [3:0]    lat_mask;
  logic [31:0]   lat_wdata;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic [AW-1:0] req_idx;
  logic          req_oob;
  logic [AW-1:0] acc_idx;
  logic          acc_oob;
  logic          acc_ren;
  logic          acc_wen;
  logic [3:0]    acc_mask;
  logic [31:0]   acc_wdata;

  assign req_idx = i_req_addr[AW+1:2];

`ifdef DMEM_RESP_RANGE_CHECK_EN
  logic unused_addr_bits;
  assign req_oob          = |i_req_addr[31:AW+2];
  assign unused_addr_bits = ^i_req_addr[1:0];
`else
  logic unused_addr_bits;
  assign req_oob          = 1'b0;
  assign unused_addr_bits = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};
`endif

  assign accept     = i_req_valid && o_req_ready;
  assign enter_resp = (state == IDLE && accept && DIRECT) || (state == WAIT && cnt == 4'd0);

  // With LATENCY=1 the access happens on the acceptance edge, so it must use the live inputs.
  always_comb begin
    acc_idx   = lat_idx;
    acc_oob   = lat_oob;
    acc_ren   = lat_ren;
    acc_wen   = lat_wen;
    acc_mask  = lat_mask;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_idx   = req_idx;
      acc_oob   = req_oob;
      acc_ren   = i_req_ren;
      acc_wen   = i_req_wen;
      acc_mask  = i_req_mask;
      acc_wdata = i_req_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DIRECT ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state == IDLE);
    o_rsp_valid = (state == RESP);
    o_dbg_state = state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= 4'd0;
      lat_idx     <= '0;
      lat_oob     <= 1'b0;
      lat_ren     <= 1'b0;
      lat_wen     <= 1'b0;
      lat_mask    <= 4'd0;
      lat_wdata   <= 32'd0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_idx   <= req_idx;
        lat_oob   <= req_oob;
        lat_ren   <= i_req_ren;
        lat_wen   <= i_req_wen;
        lat_mask  <= i_req_mask;
        lat_wdata <= i_req_wdata;
        cnt       <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        o_rsp_rdata <= (acc_ren && !acc_oob) ? mem[acc_idx] : 32'd0;
        o_rsp_err   <= acc_oob;
      end
    end
  end

  // Memory is deliberately not reset; the write is gated so a reset edge never commits one.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && enter_resp && acc_wen && !acc_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_mask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized scoreboard bench for dmem_resp: a word-array reference model predicts each
// response, a monitor pops and compares whenever the DUT presents one.
module tb_dmem_resp;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int EW    = 69;  // {hold[4], due_cycle[32], err[1], rdata[32]}

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_ren;
  logic        i_req_wen;
  logic [3:0]  i_req_mask;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [1:0]  o_dbg_state;

  dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_ren   (i_req_ren),
    .i_req_wen   (i_req_wen),
    .i_req_mask  (i_req_mask),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [31:0]   ref_mem [DEPTH];
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array updated with byte-lane writes.
  task automatic model(input logic [31:0] addr, input bit ren, input bit wen,
                       input logic [3:0] mask, input logic [31:0] wdata,
                       output logic [31:0] rdata, output bit err);
    int idx;
    bit oob;
`ifdef DMEM_RESP_RANGE_CHECK_EN
    oob = (addr >= 32'(4 * DEPTH));
`else
    oob = 1'b0;
`endif
    idx   = int'((addr >> 2) % 32'(DEPTH));
    err   = oob;
    rdata = 32'd0;
    if (!oob) begin
      if (ren) rdata = ref_mem[idx];
      if (wen) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  // driver
  task automatic do_req(input logic [31:0] addr, input bit ren, input bit wen,
                        input logic [3:0] mask, input logic [31:0] wdata,
                        input int hold, input bit garbage);
    logic [31:0] r;
    bit e;
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_req_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got 0 want 1");
      return;
    end
    i_req_addr  = addr;
    i_req_ren   = ren;
    i_req_wen   = wen;
    i_req_mask  = mask;
    i_req_wdata = wdata;
    i_req_valid = 1'b1;
    model(addr, ren, wen, mask, wdata, r, e);
    @(posedge i_clk);
    #1;
    exp_q.push_back({4'(hold), 32'(cyc + LAT), e, r});
    n = 0;
    do begin
      @(negedge i_clk);
      if (garbage && !o_req_ready) begin
        i_req_addr  = $urandom_range(0, 4 * DEPTH - 1);
        i_req_ren   = 1'($urandom);
        i_req_wen   = 1'b1;
        i_req_mask  = 4'hF;
        i_req_wdata = $urandom;
      end else begin
        i_req_valid = 1'b0;
      end
      n++;
    end while (!o_req_ready && n < 200);
    i_req_valid = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    int  hold_left;
    bit  seen;
    seen = 1'b0;
    hold_left = 0;
    i_rsp_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n || !mon_en) begin
        seen = 1'b0;
        i_rsp_ready = 1'b0;
      end else if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rdata %h with no request pending", o_rsp_rdata);
          i_rsp_ready = 1'b1;
        end else begin
          e = exp_q[0];
          if (!seen) begin
            seen = 1'b1;
            check("rsp_latency_cycle", 32'(cyc), e[64:33]);
            hold_left = int'(e[68:65]);
          end
          check("rsp_rdata", o_rsp_rdata, e[31:0]);
          check("rsp_err", {31'd0, o_rsp_err}, {31'd0, e[32]});
          check("req_ready_busy", {31'd0, o_req_ready}, 32'd0);
          if (hold_left == 0) begin
            i_rsp_ready = 1'b1;
            void'(exp_q.pop_front());
            seen = 1'b0;
          end else begin
            i_rsp_ready = 1'b0;
            hold_left--;
          end
        end
      end else begin
        i_rsp_ready = 1'b0;
        seen = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, o_rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, o_rsp_err}, 32'd0);
    check({tag, "_state"}, {30'd0, o_dbg_state}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
  endtask

  // stimulus
  initial begin
    logic [31:0] a;
    int n;
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_addr  = 32'd0;
    i_req_ren   = 1'b0;
    i_req_wen   = 1'b0;
    i_req_mask  = 4'd0;
    i_req_wdata = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    // known contents everywhere
    for (int i = 0; i < DEPTH; i++) do_req(32'(i * 4), 1'b0, 1'b1, 4'hF, $urandom, 0, 1'b0);

    do_req(32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 0, 1'b0);
    do_req(32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    do_req(32'h20, 1'b0, 1'b1, 4'hF, 32'h11223344, 0, 1'b0);
    do_req(32'h20, 1'b0, 1'b1, 4'b0010, 32'h0000AA00, 1, 1'b0);
    do_req(32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 5, 1'b1);
    do_req(32'h30, 1'b1, 1'b1, 4'b1001, 32'hA5A5A5A5, 2, 1'b0);
    do_req(32'h30, 1'b0, 1'b0, 4'hF, 32'h12345678, 0, 1'b0);
    do_req(32'h34, 1'b1, 1'b1, 4'b0000, 32'hFFFFFFFF, 0, 1'b0);
    do_req(32'h30, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0);

    // reset in WAIT abandons the write; read of 0x20 first leaves nonzero rdata behind
    do_req(32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    i_req_addr  = 32'h40;
    i_req_ren   = 1'b0;
    i_req_wen   = 1'b1;
    i_req_mask  = 4'hF;
    i_req_wdata = 32'hFFFFFFFF;
    i_req_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check("mid_wait_state", {30'd0, o_dbg_state}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_req(32'h40, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0);

    // range boundary
    do_req(32'h400, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    do_req(32'h3FC, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    do_req(32'h404, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 0, 1'b0);
    do_req(32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        7, 8:    a = $urandom_range(0, 8 * DEPTH - 1);
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      endcase
      do_req(a, 1'($urandom), 1'($urandom), 4'($urandom), $urandom,
             $urandom_range(0, 3), 1'($urandom));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words stored; power of two, 4..4096.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response valid; range 1..15.
REQ-003 The clock is i_clk, a single clock; reset is i_rst_n, asynchronous, active-low.
REQ-004 i_clk  in  1  clock; all state changes on the rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req_valid  in  1  request present.
REQ-007 o_req_ready  out  1  responder can accept a request.
REQ-008 i_req_addr  in  32  byte address; word index = i_req_addr[log2(DEPTH)+1:2]; bits [1:0] ignored.
REQ-009 i_req_ren  in  1  read request.
REQ-010 i_req_wen  in  1  write request.
REQ-011 i_req_mask  in  4  byte-lane enables; bit i is byte i of the word.
REQ-012 i_req_wdata  in  32  lane-aligned write data.
REQ-013 o_rsp_valid  out  1  response present.
REQ-014 i_rsp_ready  in  1  consumer accepts the response.
REQ-015 o_rsp_rdata  out  32  full read word.
REQ-016 o_rsp_err  out  1  address out of range; see REQ-032.

Function
REQ-017 FSM states: IDLE, WAIT, RESP. One request is outstanding at most.
REQ-018 o_req_ready SHALL be 1 only in IDLE.
REQ-019 A request is accepted on an edge where i_req_valid=1 and o_req_ready=1. On that edge the block latches addr, ren, wen, mask and wdata, and loads the counter with LATENCY-1.
REQ-020 After acceptance: if LATENCY=1, go IDLE->RESP directly; otherwise go IDLE->WAIT. In WAIT the counter decrements each cycle, and the FSM goes WAIT->RESP on the edge where the counter is 0.
REQ-021 On the edge entering RESP:
- o_rsp_rdata is loaded with the pre-write contents of the word if ren=1, else 0.
- If wen=1, each byte whose mask bit is 1 is written; bytes with mask bit 0 are unchanged.
REQ-022 Net effect: o_rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-023 ren=1 and wen=1 together: the write is performed and rdata returns the old word.
REQ-024 ren=0 and wen=0: no memory access; a response is still produced with rdata=0.
REQ-025 wen=1 with mask=0000: memory is unchanged; a response is still produced.
REQ-026 In RESP, o_rsp_valid=1, and o_rsp_rdata/o_rsp_err hold stable until i_rsp_ready=1.
REQ-027 RESP with i_rsp_ready=1 goes to IDLE on that edge, and o_rsp_valid is 0 the next cycle. Minimum request spacing is LATENCY+2 cycles.
REQ-028 Request inputs are ignored outside IDLE.
REQ-029 The counter is 4 bits and never wraps: it is only decremented in WAIT while nonzero.

Reset
REQ-030 While i_rst_n=0 the block SHALL hold:
- state = IDLE, counter = 0;
- o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0;
- o_req_ready = 1 once reset deasserts.
Memory contents are not reset.
REQ-031 Reset asserted in WAIT SHALL abandon the request, and its write SHALL NOT occur. Reset asserted in RESP drops the response; the write has already committed.

Configuration
REQ-032 Macro DMEM_RESP_RANGE_CHECK_EN.
- Defined: a request with i_req_addr >= 4*DEPTH completes with normal latency, o_rsp_err=1, rdata=0, and no write.
- Undefined: the address wraps modulo 4*DEPTH, and o_rsp_err is tied to 0.

Verification
REQ-033 Write 0xDEADBEEF, mask 1111, addr 0x10; then read addr 0x10 -> rsp_valid 2 cycles after acceptance, rdata 0xDEADBEEF.
REQ-034 Start with word 0x11223344 at 0x20. Write wdata 0x0000AA00, mask 0010; then read -> rdata 0x1122AA44.
REQ-035 Read with i_rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable for all 5; req_ready 0; a new i_req_valid is ignored.
REQ-036 Pulse i_rst_n low mid-WAIT of a write of 0xFFFFFFFF to 0x40 -> outputs 0 immediately; a later read of 0x40 returns its prior value.
REQ-037 Read addr 0x400 (DEPTH=256). With macro defined -> err=1, rdata=0. Without macro -> rdata equals the word at 0x000, err=0.
REQ-038 Set LATENCY=1 and issue back-to-back requests with rsp_ready=1 -> acceptances are 3 cycles apart, each response 1 cycle after its acceptance.
